// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M encodings and the multiply/divide unit state type.
package riscv_pkg;

  localparam logic [6:0] MULDIV = 7'b0000001;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide on one
// shared accumulator, retiring BITS_PER_CYCLE bits per CALC cycle.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_value,
  output logic [4:0]      resp_rd,
  output logic            busy
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned AW = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("riscv_muldiv: XLEN must be 32 or 64");
  end
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
    $error("riscv_muldiv: BITS_PER_CYCLE must be 1, 2 or 4");
  end
  if (XLEN % BITS_PER_CYCLE != 0) begin : g_bad_div
    $error("riscv_muldiv: XLEN must be a multiple of BITS_PER_CYCLE");
  end

  muldiv_state_t   state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [XLEN-1:0] b_q;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] value_q;

  logic            accept, fast;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_val, fix_val;

  assign accept   = (state == IDLE) && req_valid && !flush;
  assign a_signed = (req_funct3 == MULH) || (req_funct3 == MULHSU) ||
                    (req_funct3 == DIV)  || (req_funct3 == REM);
  assign b_signed = (req_funct3 == MULH) || (req_funct3 == DIV) || (req_funct3 == REM);
  assign a_neg    = a_signed && req_rs1[XLEN-1];
  assign b_neg    = b_signed && req_rs2[XLEN-1];
  assign a_mag    = a_neg ? -req_rs1 : req_rs1;
  assign b_mag    = b_neg ? -req_rs2 : req_rs2;
  assign div_zero = req_funct3[2] && (req_rs2 == '0);
  assign div_ovf  = ((req_funct3 == DIV) || (req_funct3 == REM)) &&
                    (req_rs1 == MIN_NEG) && (req_rs2 == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_val = '0;
    if (div_zero) fast_val = req_funct3[1] ? req_rs1 : '1;
    else          fast_val = req_funct3[1] ? '0 : req_rs1;
  end

  // Each stage computes both the multiply and divide step; the latched op picks one.
  logic [AW-1:0] stage [BITS_PER_CYCLE+1];
  assign stage[0] = acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [XLEN:0] sum, shifted, diff;
    logic [AW-1:0] mul_nxt, div_nxt;
    assign sum     = stage[g][AW-1:XLEN] + (stage[g][0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {1'b0, sum, stage[g][XLEN-1:1]};
    assign shifted = {stage[g][2*XLEN-1:XLEN], stage[g][XLEN-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign div_nxt = diff[XLEN] ? {shifted, stage[g][XLEN-2:0], 1'b0}
                                : {diff,    stage[g][XLEN-2:0], 1'b1};
    assign stage[g+1] = f3_q[2] ? div_nxt : mul_nxt;
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;

  assign prod     = acc[2*XLEN-1:0];
  assign quo      = acc[XLEN-1:0];
  assign rem      = acc[2*XLEN-1:XLEN];
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_q ? -rem : rem;

  always_comb begin
    fix_val = '0;
    case (f3_q)
      MUL:               fix_val = prod_fix[XLEN-1:0];
      MULH, MULHSU,
      MULHU:             fix_val = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:         fix_val = quo_fix;
      default:           fix_val = rem_fix;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) state_nxt = fast ? DONE : CALC;
        CALC: if (cnt == CW'(1)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (resp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc     <= '0;
      value_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      f3_q  <= req_funct3;
      rd_q  <= req_rd;
      b_q   <= b_mag;
      neg_q <= (req_funct3[2] && req_funct3[1]) ? a_neg : (a_neg ^ b_neg);
      acc   <= {{(XLEN+1){1'b0}}, a_mag};
      if (fast) value_q <= fast_val;
      else      cnt     <= CW'(N);
    end else if (state == CALC) begin
      acc <= stage[BITS_PER_CYCLE];
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      value_q <= fix_val;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign resp_value = value_q;
  assign resp_rd    = rd_q;

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative multiply/divide execution unit implementing the RV32M/RV64M instruction group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in operand width and bits retired per cycle. It sits beside the single-cycle integer datapath. When decode sees OP with funct7 = 0000001, the datapath issues the operands here over a valid/ready request channel. It stalls until the result returns on a valid/ready response channel, then writes it to rd.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- BITS_PER_CYCLE, 1: quotient/multiplier bits retired per CALC cycle; 1, 2 or 4. XLEN % BITS_PER_CYCLE must be 0.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; the in-flight op is dropped.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_rs1  in  XLEN  operand A (multiplicand/dividend).
- req_rs2  in  XLEN  operand B (multiplier/divisor).
- req_rd  in  5  destination tag, returned unchanged.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes result.
- resp_value  out  XLEN  result.
- resp_rd  out  5  tag of the result.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: req_ready=1. On req_valid&req_ready, latch funct3, rd, and operand magnitudes plus sign flags:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Others: both unsigned.
- Fast paths at accept, going IDLE→DONE directly:
  - Divide by zero (funct3 4–7, rs2=0): DIV/DIVU result all-ones; REM/REMU result rs1.
  - Signed overflow (DIV/REM, rs1 = most-negative, rs2 = all-ones): DIV result rs1; REM result 0.
- Otherwise go IDLE→CALC and load the counter with N = XLEN/BITS_PER_CYCLE.
- CALC, multiply: shift-add on a 2·XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
- CALC, divide: restoring division, BITS_PER_CYCLE quotient bits per cycle, XLEN+1-bit remainder.
- The counter decrements each CALC cycle. At counter=1 the next state is FIX.
- FIX, one cycle: apply sign correction.
  - Product negated when the signs differ.
  - Quotient negated when the signs differ.
  - Remainder takes the sign of the dividend.
- FIX, result select: low XLEN bits for MUL; high XLEN bits for MULH/MULHSU/MULHU; quotient or remainder for divides. Then go to DONE.
- DONE: resp_valid=1; resp_value/resp_rd stable until the handshake. On resp_ready go to IDLE.
- No new request is accepted in DONE, even on the same cycle as resp_ready.
- flush, any state: next state IDLE, resp_valid deasserted next cycle, no response for the dropped op.
  - flush has priority over both handshakes on the same edge.
- req_funct3 outside an accepted handshake is ignored. Operands are not re-sampled after accept.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_value=0, resp_rd=0, busy=0, counter=0.
- Normal latency: resp_valid rises N+2 cycles after the accept edge (N CALC + 1 FIX + entry to DONE).
  - XLEN=32, BITS_PER_CYCLE=1: 34 cycles.
  - XLEN=32, BITS_PER_CYCLE=4: 10 cycles.
- Fast-path latency: resp_valid rises 1 cycle after the accept edge.
- Throughput: at best one op per latency+1 cycles; the back-to-back gap is at least one IDLE cycle.
- Backpressure: DONE holds indefinitely while resp_ready=0; outputs do not change.
- rst asserted mid-CALC: all outputs reach their reset values immediately (asynchronous), with no response emitted.

## Structure
- Shared package riscv_pkg holds:
  - M-op funct3 localparams (MUL..REMU).
  - Funct7 constant MULDIV = 7'b0000001.
  - State enum muldiv_state_t.
- The datapath decode uses the same package constants to steer ALUR ops with funct7=MULDIV to this unit.
- Single module, no sub-module. One shared accumulator/shift register serves both multiply and divide, and the divide step is a generate loop over BITS_PER_CYCLE.
- Elaboration-time assertions: XLEN in {32,64}; BITS_PER_CYCLE in {1,2,4}; XLEN % BITS_PER_CYCLE == 0.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32, BITS_PER_CYCLE=1) → resp_value 0xFFFFFFEB, resp_rd echoed, resp_valid exactly 34 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU same operands → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV/REM, each with latency checked:
  - 0xFFFFFFF9 ÷ 2 → DIV 0xFFFFFFFD; REM 0xFFFFFFFF.
  - DIVU 100 ÷ 7 → 14; REMU → 2.
- Special cases, each with resp_valid 1 cycle after accept:
  - DIV 5 ÷ 0 → 0xFFFFFFFF; REMU 5 ÷ 0 → 5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure and flush:
  - resp_ready low for 10 cycles in DONE: value/tag stable, req_ready=0; then the handshake returns the unit to IDLE.
  - flush at CALC cycle 5 → IDLE next cycle, no response; the next request completes correctly.
- Reset: rst pulse mid-CALC → resp_valid=0 and busy=0 immediately. Repeat the MUL test at BITS_PER_CYCLE=4 → same value, 10-cycle latency.
